// File: rtl/wave_sched_pkg.sv
// rtl/wave_sched_pkg.sv - shared state encodings and default constants for wave_scheduler
package wave_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_RUNNING   = 3'd2,
        ST_PAUSED    = 3'd3,
        ST_DONE      = 3'd4
    } sched_state_t;

    localparam int SPAWN_W             = 4;
    localparam int DEF_MAX_SPAWN       = 8;
    localparam int DEF_COUNTDOWN_TICKS = 3;

endpackage

// File: rtl/slow_edge_sync.sv
// rtl/slow_edge_sync.sv - synchronizer, history register and edge strobe for the slow divided clock (WAVE_SCHED_BOTH_EDGES_EN selects both edges)
module slow_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_100MHz,
    input  logic rst,
    input  logic slow_clk_in,
    output logic tick
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   prime_q;
    logic                   primed;
    logic                   sync_out;
    logic                   hist;
    logic                   edge_hit;

    assign sync_out = sync_q[SYNC_STAGES-1];
    // Priming completes only once the reset zeros have drained out of the
    // synchronizer, so a level held high through reset never looks like an edge.
    assign primed   = prime_q[SYNC_STAGES];

`ifdef WAVE_SCHED_BOTH_EDGES_EN
    assign edge_hit = sync_out ^ hist;
`else
    assign edge_hit = sync_out & ~hist;
`endif

    // Shift the slow level through the synchronizer and register the edge strobe.
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            prime_q <= '0;
            hist    <= 1'b0;
            tick    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], slow_clk_in};
            prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b1};
            hist    <= sync_out;
            tick    <= primed & edge_hit;
        end
    end

endmodule

// File: rtl/wave_scheduler.sv
// rtl/wave_scheduler.sv - game-timing FSM turning slow clock edges into countdown, wave and spawn events (WAVE_SCHED_BOTH_EDGES_EN also counts falling edges)
module wave_scheduler
    import wave_sched_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int COUNTDOWN_TICKS = DEF_COUNTDOWN_TICKS,
    parameter int MAX_WAVE        = 20,
    parameter int MAX_SPAWN       = DEF_MAX_SPAWN,
    parameter int WAVE_W          = 8
) (
    input  logic               clk_100MHz,
    input  logic               rst,
    input  logic               slow_clk_in,
    input  logic               start,
    input  logic               pause,
    input  logic               game_over,
    output logic               tick,
    output logic               spawn_pulse,
    output logic [WAVE_W-1:0]  wave_num,
    output logic [SPAWN_W-1:0] spawn_count,
    output logic [3:0]         countdown_val,
    output logic [2:0]         state
);

    localparam logic [WAVE_W-1:0] MAX_WAVE_W  = WAVE_W'(MAX_WAVE);
    localparam logic [WAVE_W-1:0] MAX_SPAWN_W = WAVE_W'(MAX_SPAWN);
    localparam logic [3:0]        CD_INIT     = 4'(COUNTDOWN_TICKS);

    sched_state_t      st;
    logic              tick_int;
    logic [WAVE_W-1:0] wave_inc;
    logic [WAVE_W-1:0] wave_next;
    logic [WAVE_W-1:0] spawn_clamp;

    slow_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_100MHz  (clk_100MHz),
        .rst         (rst),
        .slow_clk_in (slow_clk_in),
        .tick        (tick_int)
    );

    assign tick  = tick_int;
    assign state = st;

    // Wave number never wraps; the spawn count follows it up to MAX_SPAWN.
    assign wave_inc    = wave_num + 1'b1;
    assign wave_next   = (wave_num >= MAX_WAVE_W) ? MAX_WAVE_W : wave_inc;
    assign spawn_clamp = (wave_next > MAX_SPAWN_W) ? MAX_SPAWN_W : wave_next;

    // Game FSM: game_over beats start, start beats pause, pause beats tick.
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            st            <= ST_IDLE;
            spawn_pulse   <= 1'b0;
            wave_num      <= '0;
            spawn_count   <= '0;
            countdown_val <= '0;
        end else begin
            spawn_pulse <= 1'b0;
            if (game_over && st != ST_IDLE) begin
                st <= ST_DONE;
            end else if (start && (st == ST_IDLE || st == ST_DONE)) begin
                st            <= ST_COUNTDOWN;
                wave_num      <= '0;
                spawn_count   <= '0;
                countdown_val <= CD_INIT;
            end else begin
                case (st)
                    ST_COUNTDOWN: begin
                        if (tick_int) begin
                            countdown_val <= countdown_val - 4'd1;
                            if (countdown_val == 4'd1) begin
                                st <= ST_RUNNING;
                            end
                        end
                    end
                    ST_RUNNING: begin
                        if (pause) begin
                            st <= ST_PAUSED;
                        end else if (tick_int) begin
                            spawn_pulse <= 1'b1;
                            wave_num    <= wave_next;
                            spawn_count <= spawn_clamp[SPAWN_W-1:0];
                            if (wave_next == MAX_WAVE_W) begin
                                st <= ST_DONE;
                            end
                        end
                    end
                    ST_PAUSED: begin
                        if (!pause) begin
                            st <= ST_RUNNING;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/wave_scheduler.md
# wave_scheduler

Consumes the slow divided clock from the 5 s clock divider and turns it into game-timing events in the 100 MHz domain. It treats the divided clock as a slow data signal, never as a clock. It synchronizes and edge-detects that signal, runs a pre-game countdown, then issues one single-cycle spawn pulse per tick together with an incrementing wave number and a per-wave enemy count. It sits between the clock dividers and the enemy-spawn/game-logic blocks.

## Interface
- SYNC_STAGES, 2: flip-flop stages in the synchronizer for slow_clk_in (minimum 2).
- COUNTDOWN_TICKS, 3: ticks spent in COUNTDOWN before RUNNING (1..15).
- MAX_WAVE, 20: last wave number; reaching it ends the game.
- MAX_SPAWN, 8: saturation value for spawn_count.
- WAVE_W, 8: width of wave_num (must hold MAX_WAVE).

Ports:
- clk_100MHz  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- slow_clk_in  in  1  divided clock level from the divider; asynchronous to the logic, treated as data.
- start  in  1  level; starts or restarts the game from IDLE or DONE.
- pause  in  1  level; freezes RUNNING while high.
- game_over  in  1  level; forces DONE.
- tick  out  1  single-cycle strobe, one per counted slow_clk_in edge (debug/visibility).
- spawn_pulse  out  1  single-cycle spawn request.
- wave_num  out  WAVE_W  current wave number.
- spawn_count  out  4  enemies to spawn with the current pulse.
- countdown_val  out  4  countdown ticks remaining.
- state  out  3  FSM state encoding.

## Operation
- States: IDLE=0, COUNTDOWN=1, RUNNING=2, PAUSED=3, DONE=4.
- Reset values: state IDLE; all other outputs 0.
- Synchronizer and edge detector:
  - slow_clk_in passes through SYNC_STAGES flip-flops, then one history register.
  - tick = sync_out & ~hist, i.e. rising edges only (see Configuration).
- Transition priority, highest first: rst, game_over, start, pause, tick.
- game_over while in any state other than IDLE → DONE. Outputs then hold, and spawn_pulse is 0.
- IDLE or DONE with start=1:
  - → COUNTDOWN.
  - wave_num ← 0, countdown_val ← COUNTDOWN_TICKS, spawn_count ← 0.
- start in COUNTDOWN, RUNNING or PAUSED: ignored.
- COUNTDOWN, on tick: countdown_val decrements. When the decrement reaches 0, → RUNNING. No spawn on that tick.
- RUNNING:
  - pause=1 → PAUSED. A tick in the same cycle is dropped.
  - On tick:
    - spawn_pulse=1 for one cycle.
    - wave_num ← wave_num+1.
    - spawn_count ← min(wave_num+1, MAX_SPAWN).
    - If wave_num+1 == MAX_WAVE, → DONE on the same edge. That final spawn is still issued.
- PAUSED: ticks are ignored and not queued. pause=0 → RUNNING.
- pause is ignored outside RUNNING and PAUSED.
- wave_num saturates at MAX_WAVE and never wraps.
- spawn_count arithmetic is done at WAVE_W width, then clamped to 4 bits.

## Timing
- Define E1 as the first clk_100MHz edge at which a new slow_clk_in level is sampled.
- tick is high in the cycle after edge E(SYNC_STAGES+1).
- spawn_pulse, wave_num and spawn_count update at edge E(SYNC_STAGES+2). Latency is 4 edges at the default setting.
- spawn_pulse and tick are each exactly one cycle wide.
- Minimum spacing between ticks is one slow_clk_in half-period, far above the pipeline depth.
- A slow_clk_in glitch shorter than one clk_100MHz period may be missed; that is acceptable.
- Reset asserted mid-operation clears the synchronizer, the history register, the FSM and all outputs immediately.
- After reset release, the history register is loaded from the synchronizer output without producing a tick. Implement this with an internal primed flag cleared by reset.
- state, wave_num, spawn_count and countdown_val are registered and glitch-free.

## Configuration
- WAVE_SCHED_BOTH_EDGES_EN:
  - Defined: tick = sync_out ^ hist. Both edges count, giving a 2.5 s cadence from the 5 s divider.
  - Undefined (default): rising edges only, giving a 5 s cadence.
- All other behaviour is identical in both builds.

## Structure
- Package wave_sched_pkg holds:
  - the state enum (width 3) and its encodings;
  - the spawn_count width constant (4);
  - the default MAX_SPAWN and COUNTDOWN_TICKS constants.
- Sub-module slow_edge_sync holds the parameterised SYNC_STAGES synchronizer, the history register, the primed flag and the edge selection under WAVE_SCHED_BOTH_EDGES_EN. It outputs tick.
- The top level holds the FSM, the counters and the output registers.

## Test plan
- Reset and priming:
  - Stimulus: hold slow_clk_in=1 through reset release.
  - Required: no tick; all outputs 0; state=0.
- Full game at MAX_WAVE=4, COUNTDOWN_TICKS=3:
  - Stimulus: start, then 7 rising edges.
  - Required: countdown_val goes 3→2→1→0, then state=2.
  - Required: 4 spawn pulses with wave_num 1..4 and spawn_count 1..4.
  - Required: state=4 on the 4th pulse.
- Latency:
  - Stimulus: raise slow_clk_in.
  - Required: spawn_pulse high after exactly 4 clk_100MHz edges (SYNC_STAGES=2); width 1 cycle.
- Pause:
  - Stimulus: pause asserted in the same cycle as a tick in RUNNING, then 2 more ticks, then pause released.
  - Required: no spawn; wave_num unchanged; the next tick after release gives wave_num+1.
- Override and restart:
  - Stimulus: game_over together with start and tick in RUNNING.
  - Required: state=4 and no spawn.
  - Stimulus: later, start alone.
  - Required: state=1, wave_num=0.
- Saturation and both-edges build:
  - Stimulus: MAX_SPAWN=2, wave 5.
  - Required: spawn_count=2.
  - Stimulus: build with WAVE_SCHED_BOTH_EDGES_EN.
  - Required: a falling edge also produces a tick.
